man_coord_gen: RTL
==================

Name: man_coord_gen

Overview:
- Upstream stage of the Mandelbrot per-pixel compute stage.
- Scans a frame in raster order: px 0..H_RES-1 within py 0..V_RES-1.
- Emits, per pixel, the integer coordinates plus the complex constant c = (cr, ci) in signed fixed point.
- Uses incremental accumulation, no multipliers, over a valid/ready handshake. The compute stage consumes each beat and seeds z = 0 itself.

Parameters:
- H_RES, 640, pixels per line (max 1024, px is 10 bits)
- V_RES, 480, lines per frame (max 512, py is 9 bits)
- COORD_W, 32, width of cr/ci and of the config words; signed two's complement
- FRAC_W, 28, fractional bits (Q4.28: 1.0 = 0x10000000)

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low
- start  in  1  one-cycle pulse; begins a frame when idle
- offset_re  in  COORD_W  real part of c at px=0
- offset_im  in  COORD_W  imag part of c at py=0
- step_re  in  COORD_W  real increment per pixel
- step_im  in  COORD_W  imag increment per line
- busy  out  1  high while a frame is being issued
- done  out  1  one-cycle pulse after the last pixel is accepted
- m_valid  out  1  beat valid
- m_ready  in  1  downstream accepts
- px  out  10  pixel column
- py  out  9  pixel row
- cr  out  COORD_W  real part of c
- ci  out  COORD_W  imag part of c
- sof  out  1  beat is pixel (0,0)
- eol  out  1  beat is px = H_RES-1

Behaviour:
- Clocking and reset: single clock aclk; reset aresetn is synchronous and active-low, sampled on the rising edge.
- Reset values: all outputs 0; state IDLE; latched config cleared.
- Reset mid-frame: aborts immediately, returns to IDLE with m_valid=0; no done pulse.

States:
- IDLE, start=1:
  - latch offset_re, offset_im, step_re, step_im
  - next cycle: state RUN, busy=1, m_valid=1, px=0, py=0, cr=offset_re, ci=offset_im, sof=1
  - start-to-first-beat latency is 1 cycle.
- RUN: a beat transfers when m_valid && m_ready.
  - While m_valid && !m_ready: px, py, cr, ci, sof, eol are held stable.
  - On transfer with px < H_RES-1: px+1, cr += step_re.
  - On transfer with px = H_RES-1 and py < V_RES-1: px=0, py+1, cr=offset_re, ci += step_im.
  - On transfer of the last pixel (H_RES-1, V_RES-1): next cycle state IDLE, m_valid=0, busy=0, done=1 for one cycle.
- Throughput: m_valid stays high throughout RUN; one beat per cycle when m_ready is held high.
- Frame length: exactly H_RES*V_RES beats per frame.

Arithmetic and flags:
- Additions are COORD_W-bit two's complement, wrapping silently.
- Config inputs are ignored outside the IDLE-start cycle.
- start during RUN is ignored; the frame is not restarted.
- sof/eol are combinational functions of the registered px/py, so they are consistent with the beat.

Optional Feature:
- MAN_COORD_CONTINUOUS_EN defined:
  - After the last pixel is accepted, done still pulses.
  - The generator relatches the current config inputs and restarts at (0,0) in the next cycle: m_valid stays high, busy stays 1, no idle cycle.
  - Frames then repeat until reset. start is only needed for the first frame.
- Undefined: single-shot behaviour as above.

Decomposition:
- Shared package man_pkg:
  - COORD_W, FRAC_W, default H_RES/V_RES
  - typedef fx_t (signed [COORD_W-1:0])
  - state enum {IDLE, RUN}
  - constant FX_ONE = 1<<FRAC_W
- Natural sub-module: man_fx_acc, a load/add accumulator with hold, instantiated twice (re: load at line start; im: load at frame start).
- Counters and FSM live in the top module.

Test Plan:
- H_RES=4, V_RES=3, offset_re=0xE0000000 (-2.0), offset_im=0xF0000000 (-1.0), step_re=0x04000000, step_im=0x08000000, m_ready=1:
  - 12 consecutive beats
  - beat 3: cr=0xEC000000, eol=1
  - beat 4: px=0, py=1, cr=0xE0000000, ci=0xF8000000
  - done pulses one cycle after beat 11.
- Backpressure: drive m_ready low for 5 cycles at beat 2 -> px/py/cr/ci stable through the stall; no beat lost or duplicated; total still 12.
- start pulsed during RUN with different offsets -> ignored; values follow the original config; exactly one done.
- Reset asserted at beat 6 -> next cycle m_valid=0, busy=0, done=0; a new start produces sof at (0,0) with freshly latched config.
- Wrap: offset_re=0x7FFFFFFF, step_re=1 -> beat 1 cr=0x80000000, no error.
- With MAN_COORD_CONTINUOUS_EN: 3 frames back-to-back -> 36 beats, no gap; sof on beats 0, 12, 24; done after beats 11, 23, 35.

Source files
------------

// File: rtl/man_pkg.sv
// -----------------------------------------------------------------------------
// man_pkg
// Shared definitions for the Mandelbrot coordinate generator:
//   COORD_W / FRAC_W  - fixed-point format of c (Q4.28, signed)
//   H_RES_DEF/V_RES_DEF - default frame geometry
//   fx_t              - signed fixed-point word
//   state_t           - generator FSM states
//   FX_ONE            - fixed-point 1.0
// -----------------------------------------------------------------------------
package man_pkg;

    localparam int COORD_W   = 32;
    localparam int FRAC_W    = 28;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    typedef logic signed [COORD_W-1:0] fx_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam fx_t FX_ONE = fx_t'(64'(1) << FRAC_W);

endpackage

// File: rtl/man_fx_acc.sv
// -----------------------------------------------------------------------------
// man_fx_acc
// Fixed-point accumulator with load, add and hold. Load has priority over add;
// additions wrap silently at COORD_W bits.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_load, i_load_val   replace the accumulator with i_load_val
//   i_add, i_step        add i_step to the accumulator
//   o_q                  current accumulator value
// -----------------------------------------------------------------------------
module man_fx_acc
    import man_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [COORD_W-1:0] i_load_val,
    input  logic               i_add,
    input  logic [COORD_W-1:0] i_step,
    output logic [COORD_W-1:0] o_q
);

    logic [COORD_W-1:0] r_acc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_load_val;
        end else if (i_add) begin
            r_acc <= r_acc + i_step;
        end
    end

    assign o_q = r_acc;

endmodule

// File: rtl/man_coord_gen.sv
// -----------------------------------------------------------------------------
// man_coord_gen
// Raster-order pixel coordinate generator feeding the Mandelbrot compute stage.
// Each beat carries px/py and c = (cr, ci), built incrementally from the
// offsets and steps latched at frame start (no multipliers).
//
// Build option: define MAN_COORD_CONTINUOUS_EN to restart a new frame right
// after the last pixel, relatching the config inputs, until reset.
//
// state | meaning
// IDLE  | waiting for start, m_valid low
// RUN   | issuing beats, m_valid and busy high
//
// Ports:
//   aclk, aresetn       clock, synchronous active-low reset
//   start               one-cycle pulse, begins a frame when idle
//   offset_re/_im       c at px=0 / py=0
//   step_re/_im         increment per pixel / per line
//   busy, done          frame in progress / pulse after last pixel accepted
//   m_valid, m_ready    beat handshake
//   px, py, cr, ci      beat payload
//   sof, eol            beat is (0,0) / beat is last pixel of a line
// -----------------------------------------------------------------------------
module man_coord_gen
    import man_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic [COORD_W-1:0] offset_re,
    input  logic [COORD_W-1:0] offset_im,
    input  logic [COORD_W-1:0] step_re,
    input  logic [COORD_W-1:0] step_im,
    output logic               busy,
    output logic               done,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [9:0]         px,
    output logic [8:0]         py,
    output logic [COORD_W-1:0] cr,
    output logic [COORD_W-1:0] ci,
    output logic               sof,
    output logic               eol
);

`ifdef MAN_COORD_CONTINUOUS_EN
    localparam bit CONTINUOUS = 1'b1;
`else
    localparam bit CONTINUOUS = 1'b0;
`endif

    localparam logic [9:0] PX_LAST = 10'(H_RES - 1);
    localparam logic [8:0] PY_LAST = 9'(V_RES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [9:0]         r_px;
    logic [8:0]         r_py;
    logic [COORD_W-1:0] r_off_re;
    logic [COORD_W-1:0] r_step_re;
    logic [COORD_W-1:0] r_step_im;
    logic               r_done;

    logic               w_run;
    logic               w_xfer;
    logic               w_px_last;
    logic               w_py_last;
    logic               w_last;
    logic               w_frame_start;
    logic               w_re_load;
    logic [COORD_W-1:0] w_re_load_val;
    logic               w_im_add;

    assign w_run     = (r_state == RUN);
    assign w_xfer    = w_run && m_ready;
    assign w_px_last = (r_px == PX_LAST);
    assign w_py_last = (r_py == PY_LAST);
    assign w_last    = w_xfer && w_px_last && w_py_last;

    // Frame start takes config straight from the inputs so the first beat
    // is ready one cycle after start; the imaginary offset lives only in the
    // ci accumulator since it is never reloaded mid-frame.
    assign w_frame_start = ((r_state == IDLE) && start) || (CONTINUOUS && w_last);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = RUN;
            RUN:  if (w_last && !CONTINUOUS) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_px      <= '0;
            r_py      <= '0;
            r_off_re  <= '0;
            r_step_re <= '0;
            r_step_im <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last;
            if (w_frame_start) begin
                r_off_re  <= offset_re;
                r_step_re <= step_re;
                r_step_im <= step_im;
                r_px      <= '0;
                r_py      <= '0;
            end else if (w_xfer) begin
                if (w_px_last) begin
                    r_px <= '0;
                    r_py <= w_py_last ? '0 : r_py + 9'd1;
                end else begin
                    r_px <= r_px + 10'd1;
                end
            end
        end
    end

    assign w_re_load     = w_frame_start || (w_xfer && w_px_last);
    assign w_re_load_val = w_frame_start ? offset_re : r_off_re;
    assign w_im_add      = w_xfer && w_px_last && !w_py_last;

    man_fx_acc u_acc_re (
        .i_clk      (aclk),
        .i_rst_n    (aresetn),
        .i_load     (w_re_load),
        .i_load_val (w_re_load_val),
        .i_add      (w_xfer),
        .i_step     (r_step_re),
        .o_q        (cr)
    );

    man_fx_acc u_acc_im (
        .i_clk      (aclk),
        .i_rst_n    (aresetn),
        .i_load     (w_frame_start),
        .i_load_val (offset_im),
        .i_add      (w_im_add),
        .i_step     (r_step_im),
        .o_q        (ci)
    );

    assign busy    = w_run;
    assign m_valid = w_run;
    assign done    = r_done;
    assign px      = r_px;
    assign py      = r_py;
    // Gated by m_valid so the reset/idle value of sof is 0.
    assign sof     = w_run && (r_px == 10'd0) && (r_py == 9'd0);
    assign eol     = w_run && w_px_last;

endmodule
